// File: rtl/sort_pkg.sv
// Shared types for the 8x8-bit sorter datapath: element/frame types and
// the packer state enum.
package sort_pkg;

    localparam int unsigned N_ELEM = 8;
    localparam int unsigned ELEM_W = 8;

    typedef logic [ELEM_W-1:0]        elem_t;
    typedef logic [N_ELEM*ELEM_W-1:0] frame_t;

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

endpackage

// File: rtl/sort_8x8b_packer.sv
// Byte-stream to 64-bit frame packer feeding the sorting network; double
// buffered (fill buffer + output register) for bubble-free throughput.
module sort_8x8b_packer
    import sort_pkg::*;
#(
    parameter elem_t PAD = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [3:0]   out_count,
    output logic         out_last
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    frame_t      buf_q, buf_d;
    logic [3:0]  hold_count_q, hold_count_d;
    logic        hold_last_q, hold_last_d;
    frame_t      out_data_q, out_data_d;
    logic [3:0]  out_count_q, out_count_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;

    frame_t      fill_frame;
    logic        accept, drain, close;
    logic        load;
    frame_t      load_data;
    logic [3:0]  load_count;
    logic        load_last;

    always_comb begin
        // Lanes start as PAD at frame start, so unfilled lanes are already padded on close.
        fill_frame = (idx_q == 3'd0) ? {N_ELEM{PAD}} : buf_q;
        fill_frame[{idx_q, 3'b000} +: ELEM_W] = in_data;

        in_ready = (state_q == FILL) && !rst;
        accept   = in_valid && in_ready;
        drain    = out_valid_q && out_ready;
        close    = accept && (in_last || (idx_q == 3'd7));

        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        hold_count_d = hold_count_q;
        hold_last_d  = hold_last_q;
        load         = 1'b0;
        load_data    = fill_frame;
        load_count   = {1'b0, idx_q} + 4'd1;
        load_last    = in_last;

        unique case (state_q)
            FILL: begin
                if (close) begin
                    idx_d = 3'd0;
                    if (!out_valid_q || drain) begin
                        load = 1'b1;
                    end else begin
                        buf_d        = fill_frame;
                        hold_count_d = {1'b0, idx_q} + 4'd1;
                        hold_last_d  = in_last;
                        state_d      = HOLD;
                    end
                end else if (accept) begin
                    buf_d = fill_frame;
                    idx_d = idx_q + 3'd1;
                end
            end
            HOLD: begin
                if (drain) begin
                    load       = 1'b1;
                    load_data  = buf_q;
                    load_count = hold_count_q;
                    load_last  = hold_last_q;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        out_valid_d = load || (out_valid_q && !drain);
        out_data_d  = load ? load_data  : out_data_q;
        out_count_d = load ? load_count : out_count_q;
        out_last_d  = load ? load_last  : out_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= 3'd0;
            buf_q        <= '0;
            hold_count_q <= 4'd0;
            hold_last_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= 4'd0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            hold_count_q <= hold_count_d;
            hold_last_q  <= hold_last_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/sort_8x8b_packer.md
# sort_8x8b_packer

Upstream feeder for the 8-element, 8-bit combinational sorting network. It accepts a byte stream under a valid/ready handshake and packs bytes into 64-bit frames, closing a frame early on `in_last` and padding the unused lanes. It presents each frame, registered, on a valid/ready output whose `out_data` drives the sorter's `data_in` directly. Double buffering (fill buffer plus output register) sustains one frame per 8 input beats with no bubbles.

## Interface
- `N_ELEM`, 8, elements per frame; fixed at 8 for this sorter.
- `ELEM_W`, 8, element width in bits.
- `PAD`, 8'h00, value written to unfilled lanes of a short frame.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block can accept a byte.
- `in_data`  in  8  input element.
- `in_last`  in  1  byte is the last of a frame.
- `out_valid`  out  1  `out_data` holds a complete frame.
- `out_ready`  in  1  downstream accepts the frame.
- `out_data`  out  64  packed frame; element k sits at [8k+7:8k].
- `out_count`  out  4  real elements in the frame, 1..8.
- `out_last`  out  1  frame was closed by `in_last`, not by filling 8 lanes.

## Operation
- **Accept:** a beat is accepted when `in_valid && in_ready`. The first byte of a frame goes to lane 0, the next to lane 1, and so on. The fill index `idx` runs 0..7.
- **Close condition:** the frame closes on an accepted beat with `in_last=1` or with `idx==7`. Remaining lanes idx+1..7 are set to `PAD`.
  - `out_count = idx+1`.
  - `out_last = in_last` of the closing beat.
  - An 8-byte frame with `in_last` on byte 8 gives count 8 and last 1.
  - A frame longer than 8 bytes continues in the next frame.
- **State machine** (resets to FILL):
  - **FILL:** `in_ready=1`.
    - Closing beat with the output register empty, or being drained this cycle: the frame moves straight to the output register; stay in FILL with `idx=0`.
    - Closing beat with the output register full and not draining: go to HOLD.
  - **HOLD:** `in_ready=0`; the complete frame waits in the fill buffer.
    - On `out_valid && out_ready`, the held frame loads into the output register in the same cycle; go to FILL with `idx=0`.
- **Output register:**
  - `out_valid` sets on load and clears on handshake unless a new load happens in the same cycle.
  - While `out_valid=1 && out_ready=0`, `out_data`, `out_count` and `out_last` are held stable.
- **Simultaneous drain and close:** if a closing beat and an output handshake occur in the same cycle, the new frame loads and `out_valid` stays 1.
- **Reset mid-frame:** any partial frame is discarded and no output is emitted for it.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_count=0`, `out_last=0`, `idx=0`, state FILL. `in_ready` is forced to 0 while `rst=1` and is 1 from the first cycle after release.
- **Latency:** `out_valid` rises the cycle after the closing beat is accepted (HOLD case: the cycle after the draining handshake).
- **Throughput:** with `out_ready` held at 1, one frame per 8 accepted beats; `in_ready` never drops.
- **Backpressure:** with `out_ready=0`, one frame is stored in the output register and one in the fill buffer. `in_ready` falls the cycle after the second frame closes.
- **Combinational paths:** `in_ready` depends only on registered state, never combinationally on `out_ready`. No combinational path from the input port to the output port.

## Structure
- **Shared package `sort_pkg`:** `ELEM_W`, `N_ELEM`, `elem_t` (logic [7:0]), `frame_t` (logic [63:0]), and the state enum {FILL, HOLD}. The sorter and a future output unpacker use the same package.
- **Module:** single module, no sub-module. The output register is small enough to stay inline.

## Test plan
- After reset, bytes 0x11..0x88 streamed with `in_last` on 0x88 and `out_ready=1` → `out_data=64'h8877665544332211`, count 8, last 1, `out_valid` for exactly one cycle, one cycle after the 8th accept.
- Frame 0xA0, 0xB0, 0xC0 with `in_last` on 0xC0, `PAD=0x00` → `out_data=64'h0000000000C0B0A0`, count 3, last 1.
- 10 bytes 0x01..0x0A with `in_last` on the 10th → frame 1: 64'h0807060504030201, count 8, last 0; frame 2: 64'h0000000000000A09, count 2, last 1.
- `out_ready=0`, stream 16 bytes:
  - Frame 1 holds stable on the output.
  - `in_ready` falls after the 16th byte.
  - Raising `out_ready` for 2 cycles delivers both frames in order, then `in_ready` returns to 1.
- Continuous stream with `out_ready=1` over 64 bytes → 8 frames; `in_ready` stays 1 throughout; a close coinciding with a handshake keeps `out_valid=1`.
- Assert `rst` after 5 bytes, release, send 0xFF ×8 → the only output is 64'hFFFFFFFFFFFFFFFF, count 8; no partial frame is emitted.
